// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU with combinational flags and a registered flag copy
//
// Ports:
//   clk                      rising-edge clock for the flag register
//   reset                    asynchronous active-high clear of the registered flags
//   operandA, operandB [31:0] two's complement operands
//   command [2:0]            0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
//   result [31:0]            combinational result
//   zero, carryout, overflow combinational status
//   zero_q, carryout_q, overflow_q  status registered on every rising edge
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [2:0]  command,
    output logic [31:0] result,
    output logic        zero,
    output logic        carryout,
    output logic        overflow,
    output logic        zero_q,
    output logic        carryout_q,
    output logic        overflow_q
);

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    logic        w_sub;
    logic [31:0] w_b_eff;
    logic [32:0] w_sum_ext;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_ovf;

    // One shared adder: ADD uses B directly, SUB and SLT use A + ~B + 1.
    assign w_sub     = (command != CMD_ADD);
    assign w_b_eff   = w_sub ? ~operandB : operandB;
    assign w_sum_ext = {1'b0, operandA} + {1'b0, w_b_eff} + {32'd0, w_sub};
    assign w_sum     = w_sum_ext[31:0];
    assign w_cout    = w_sum_ext[32];
    // Signed overflow: operands agree in sign but the sum does not.
    assign w_ovf     = (operandA[31] == w_b_eff[31]) && (w_sum[31] != operandA[31]);

    always_comb begin
        result   = 32'd0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (command)
            CMD_ADD, CMD_SUB: begin
                result   = w_sum;
                carryout = w_cout;
                overflow = w_ovf;
            end
            CMD_XOR:  result = operandA ^ operandB;
            // Sign XOR overflow keeps the compare correct across the full signed range.
            CMD_SLT:  result = {31'd0, w_sum[31] ^ w_ovf};
            CMD_AND:  result = operandA & operandB;
            CMD_NAND: result = ~(operandA & operandB);
            CMD_NOR:  result = ~(operandA | operandB);
            CMD_OR:   result = operandA | operandB;
            default:  result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

    logic r_zero;
    logic r_carryout;
    logic r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero     <= 1'b0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_zero     <= zero;
            r_carryout <= carryout;
            r_overflow <= overflow;
        end
    end

    assign zero_q     = r_zero;
    assign carryout_q = r_carryout;
    assign overflow_q = r_overflow;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard testbench for alu
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [2:0]  command;
    logic [31:0] result;
    logic        zero;
    logic        carryout;
    logic        overflow;
    logic        zero_q;
    logic        carryout_q;
    logic        overflow_q;

    alu dut (
        .clk        (clk),
        .reset      (reset),
        .operandA   (operandA),
        .operandB   (operandB),
        .command    (command),
        .result     (result),
        .zero       (zero),
        .carryout   (carryout),
        .overflow   (overflow),
        .zero_q     (zero_q),
        .carryout_q (carryout_q),
        .overflow_q (overflow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    logic tb_valid;
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one vector on the falling edge and record what it should produce.
    task automatic apply(input int id, input logic [2:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input logic z, input logic c, input logic o);
        exp_t e;
        @(negedge clk);
        command  = cmd;
        operandA = a;
        operandB = b;
        e.id = id; e.res = r; e.z = z; e.c = c; e.o = o;
        exp_q.push_back(e);
        tb_valid = 1'b1;
    endtask

    // Monitor: after each rising edge, the vector driven on the preceding
    // falling edge must show on the combinational outputs and in the flag register.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (tb_valid) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    checks++;
                    $display("FAIL scoreboard_empty actual=0 required=1");
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("v%0d_result", e.id), result, e.res);
                    chk($sformatf("v%0d_zero", e.id), {31'd0, zero}, {31'd0, e.z});
                    chk($sformatf("v%0d_carryout", e.id), {31'd0, carryout}, {31'd0, e.c});
                    chk($sformatf("v%0d_overflow", e.id), {31'd0, overflow}, {31'd0, e.o});
                    chk($sformatf("v%0d_zero_q", e.id), {31'd0, zero_q}, {31'd0, e.z});
                    chk($sformatf("v%0d_carryout_q", e.id), {31'd0, carryout_q}, {31'd0, e.c});
                    chk($sformatf("v%0d_overflow_q", e.id), {31'd0, overflow_q}, {31'd0, e.o});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cycles;
        checks   = 0;
        failures = 0;
        tb_valid = 1'b0;
        reset    = 1'b1;
        command  = 3'd0;
        operandA = 32'd0;
        operandB = 32'd0;

        // Reset state: registered flags clear, combinational path unaffected.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_zero_q", {31'd0, zero_q}, 32'd0);
        chk("reset_carryout_q", {31'd0, carryout_q}, 32'd0);
        chk("reset_overflow_q", {31'd0, overflow_q}, 32'd0);
        chk("reset_comb_zero", {31'd0, zero}, 32'd1);

        @(negedge clk);
        reset = 1'b0;

        //      id cmd   A             B             result        z     c     o
        apply( 0, 3'd0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        apply( 1, 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
        apply( 2, 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
        apply( 3, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0);
        apply( 4, 3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
        apply( 5, 3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        apply( 6, 3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1);
        apply( 7, 3'd2, 32'hFFFFFFFF, 32'h003FFFFF, 32'hFFC00000, 1'b0, 1'b0, 1'b0);
        apply( 8, 3'd5, 32'hFFFFFFFF, 32'h003FFFFF, 32'hFFC00000, 1'b0, 1'b0, 1'b0);
        apply( 9, 3'd6, 32'hFFFFFFFF, 32'h003FFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
        apply(10, 3'd4, 32'hFFFFFFFF, 32'h003FFFFF, 32'h003FFFFF, 1'b0, 1'b0, 1'b0);
        apply(11, 3'd7, 32'hDFFFFFFF, 32'h003FFFFF, 32'hDFFFFFFF, 1'b0, 1'b0, 1'b0);
        apply(12, 3'd3, 32'hFFFFFFFF, 32'h003FFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        apply(13, 3'd3, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
        apply(14, 3'd3, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        apply(15, 3'd3, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0);
        apply(16, 3'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
        apply(17, 3'd7, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 5) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        @(negedge clk);
        tb_valid = 1'b0;

        // Load zero_q = 1, then assert reset mid-cycle: flags clear at once.
        command  = 3'd1;
        operandA = 32'h0000BEEF;
        operandB = 32'h0000BEEF;
        @(posedge clk);
        #1;
        chk("pre_reset_zero_q", {31'd0, zero_q}, 32'd1);
        chk("pre_reset_carryout_q", {31'd0, carryout_q}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_zero_q", {31'd0, zero_q}, 32'd0);
        chk("async_reset_carryout_q", {31'd0, carryout_q}, 32'd0);
        chk("async_reset_overflow_q", {31'd0, overflow_q}, 32'd0);
        chk("async_reset_comb_zero", {31'd0, zero}, 32'd1);

        // Release reset with SUB A=B applied: zero_q rises only at the next edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_release_zero_q_before_edge", {31'd0, zero_q}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_release_zero_q_after_edge", {31'd0, zero_q}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
